// File: rtl/conv_bias_stream_gen_pkg.sv
// Shared types and defaults for the Conv-engine bias stream generator.
// Mode encodings, FSM states, and the raw-mode decoder live here.
package conv_bias_stream_gen_pkg;

    localparam int BM_DATA_WIDTH = 512;
    localparam int BM_DEPTH      = 4096;
    localparam int M_DEFAULT     = 64;

    typedef enum logic [1:0] {
        BIAS_MODE_CH    = 2'd0,
        BIAS_MODE_BCAST = 2'd1,
        BIAS_MODE_ZERO  = 2'd2,
        BIAS_MODE_RSVD  = 2'd3
    } bias_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } gen_state_e;

    // The reserved encoding behaves exactly like zero-bias mode.
    function automatic bias_mode_e decode_mode(input logic [1:0] mode_raw);
        bias_mode_e m;
        case (mode_raw)
            2'd0:    m = BIAS_MODE_CH;
            2'd1:    m = BIAS_MODE_BCAST;
            default: m = BIAS_MODE_ZERO;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/conv_bias_stream_gen_word_fifo.sv
// First-word-fall-through buffer holding whole BM words awaiting unpack.
// srst empties the buffer synchronously; pushes into a full buffer are ignored.
module conv_bias_word_fifo #(
    parameter int DW    = 512,
    parameter int DEPTH = 4,
    localparam int CW   = $clog2(DEPTH + 1),
    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          srst,
    input  logic          push,
    input  logic [DW-1:0] din,
    input  logic          pop,
    output logic [DW-1:0] dout,
    output logic [CW-1:0] count,
    output logic          empty,
    output logic          full
);

    logic [DW-1:0] mem_r [DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          do_push_s;
    logic          do_pop_s;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1)) begin
            return '0;
        end else begin
            return p + PW'(1);
        end
    endfunction

    assign empty     = (count_r == '0);
    assign full      = (count_r == CW'(DEPTH));
    assign do_push_s = push && !full;
    assign do_pop_s  = pop && !empty;
    assign dout      = mem_r[rd_ptr_r];
    assign count     = count_r;

    // Pointer and occupancy tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else if (srst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= ptr_inc(wr_ptr_r);
            end
            if (do_pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Word storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

endmodule

// File: rtl/conv_bias_stream_gen.sv
// Bias feeder: reads bias words from BM, unpacks lanes into the Bias FIFO,
// repeating the sequence per X round; supports broadcast and zero-bias modes.
module conv_bias_stream_gen
    import conv_bias_stream_gen_pkg::*;
#(
    parameter int BM_DW    = BM_DATA_WIDTH,
    parameter int BM_AW    = $clog2(BM_DEPTH),
    parameter int BIAS_W   = 64,
    parameter int M        = M_DEFAULT,
    parameter int RD_LAT   = 2,
    parameter int WF_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_pulse,
    input  logic              abort,
    input  logic [1:0]        mode,
    input  logic [BM_AW-1:0]  B_addr,
    input  logic [15:0]       n_X_rnd_minus_1,
    input  logic [15:0]       n_W_rnd_minus_1,
    output logic              busy,
    output logic              done,
    output logic              bm_rd_en,
    output logic [BM_AW-1:0]  bm_rd_addr,
    input  logic [BM_DW-1:0]  bm_dout,
    input  logic              bm_dout_vld,
    output logic              fifo_wr_en,
    output logic [BIAS_W-1:0] fifo_din,
    input  logic              fifo_prog_full
);

    localparam int N      = BM_DW / BIAS_W;
    localparam int LANE_W = (N > 1) ? $clog2(N) : 1;
    localparam int CW     = $clog2(WF_DEPTH + 1);
    localparam int IW     = CW + 1;

    if (M % N != 0) begin : g_bad_m
        $error("conv_bias_stream_gen: M must be a multiple of BM_DW/BIAS_W");
    end
    if (WF_DEPTH < RD_LAT + 2) begin : g_bad_depth
        $error("conv_bias_stream_gen: WF_DEPTH must be at least RD_LAT+2");
    end

    gen_state_e        state_r;
    gen_state_e        state_next;
    bias_mode_e        mode_r;
    logic [BM_AW-1:0]  base_addr_r;
    logic [BM_AW-1:0]  addr_r;
    logic [15:0]       nx_r;
    logic [15:0]       x_cnt_r;
    logic [31:0]       w_cnt_r;
    logic [31:0]       wpr_r;
    logic [31:0]       total_r;
    logic [31:0]       wr_cnt_r;
    logic [LANE_W-1:0] lane_r;
    logic [IW-1:0]     inflight_r;
    logic [IW-1:0]     drop_r;
    logic [BIAS_W-1:0] bcast_r;
    logic              bcast_vld_r;

    logic              busy_r;
    logic              done_r;
    logic              bm_rd_en_r;
    logic [BM_AW-1:0]  bm_rd_addr_r;
    logic              fifo_wr_en_r;
    logic [BIAS_W-1:0] fifo_din_r;

    logic              start_s;
    logic              active_s;
    logic              credit_ok_s;
    logic              issue_s;
    logic              round_end_s;
    logic              last_word_s;
    logic              rd_data_ok_s;
    logic              data_drop_s;
    logic              push_s;
    logic              pop_s;
    logic              emit_ok_s;
    logic              emit_s;
    logic              last_emit_s;
    logic [BIAS_W-1:0] emit_data_s;
    logic [IW-1:0]     inflight_upd_s;

    logic [BM_DW-1:0]  wf_dout;
    logic [CW-1:0]     wf_count;
    logic              wf_empty;
    logic              wf_full;

    assign start_s     = (state_r == ST_IDLE) && start_pulse && !abort;
    assign active_s    = (state_r == ST_RUN) || (state_r == ST_DRAIN);
    // Buffered plus outstanding words must never exceed the buffer, so no return can be lost.
    assign credit_ok_s = (IW'(wf_count) + inflight_r) < IW'(WF_DEPTH);
    assign issue_s     = (state_r == ST_RUN) && !abort && (mode_r != BIAS_MODE_ZERO) && credit_ok_s;
    assign round_end_s = (w_cnt_r == wpr_r - 32'd1);
    assign last_word_s = (mode_r == BIAS_MODE_BCAST) || ((x_cnt_r == nx_r) && round_end_s);

    // Returns belonging to an aborted operation are discarded in order.
    assign data_drop_s  = bm_dout_vld && (drop_r != '0);
    assign rd_data_ok_s = bm_dout_vld && (drop_r == '0) && active_s;
    assign push_s       = rd_data_ok_s && (mode_r == BIAS_MODE_CH) && !wf_full;

    assign emit_s      = emit_ok_s && active_s && !fifo_prog_full && !abort;
    assign pop_s       = emit_s && (mode_r == BIAS_MODE_CH) && (lane_r == LANE_W'(N - 1));
    assign last_emit_s = emit_s && (wr_cnt_r == total_r - 32'd1);

    assign inflight_upd_s = inflight_r + IW'(issue_s) - IW'(rd_data_ok_s);

    conv_bias_word_fifo #(
        .DW    (BM_DW),
        .DEPTH (WF_DEPTH)
    ) u_word_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .srst  (abort),
        .push  (push_s),
        .din   (bm_dout),
        .pop   (pop_s),
        .dout  (wf_dout),
        .count (wf_count),
        .empty (wf_empty),
        .full  (wf_full)
    );

    // Source selection for the next bias value.
    always_comb begin
        emit_ok_s   = 1'b0;
        emit_data_s = '0;
        case (mode_r)
            BIAS_MODE_CH: begin
                emit_ok_s   = !wf_empty;
                emit_data_s = wf_dout[lane_r * BIAS_W +: BIAS_W];
            end
            BIAS_MODE_BCAST: begin
                emit_ok_s   = bcast_vld_r;
                emit_data_s = bcast_r;
            end
            default: begin
                emit_ok_s   = 1'b1;
                emit_data_s = '0;
            end
        endcase
    end

    // Next-state logic; abort overrides everything, including a coincident start.
    always_comb begin
        state_next = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_s) begin
                    state_next = ST_RUN;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_next = ST_IDLE;
                end else if (last_emit_s) begin
                    state_next = ST_DONE;
                end else if (issue_s && last_word_s) begin
                    state_next = ST_DRAIN;
                end else begin
                    state_next = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (abort) begin
                    state_next = ST_IDLE;
                end else if (last_emit_s) begin
                    state_next = ST_DONE;
                end else begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next;
        end
    end

    // Instruction latch, address/round counters, lane index and write count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_r      <= BIAS_MODE_CH;
            base_addr_r <= '0;
            addr_r      <= '0;
            nx_r        <= 16'd0;
            x_cnt_r     <= 16'd0;
            w_cnt_r     <= 32'd0;
            wpr_r       <= 32'd0;
            total_r     <= 32'd0;
            wr_cnt_r    <= 32'd0;
            lane_r      <= '0;
            bcast_r     <= '0;
            bcast_vld_r <= 1'b0;
        end else if (start_s) begin
            mode_r      <= decode_mode(mode);
            base_addr_r <= B_addr;
            addr_r      <= B_addr;
            nx_r        <= n_X_rnd_minus_1;
            x_cnt_r     <= 16'd0;
            w_cnt_r     <= 32'd0;
            wpr_r       <= (32'(n_W_rnd_minus_1) + 32'd1) * 32'(M / N);
            total_r     <= (32'(n_X_rnd_minus_1) + 32'd1) * (32'(n_W_rnd_minus_1) + 32'd1) * 32'(M);
            wr_cnt_r    <= 32'd0;
            lane_r      <= '0;
            bcast_vld_r <= 1'b0;
        end else if (abort) begin
            lane_r      <= '0;
            bcast_vld_r <= 1'b0;
        end else begin
            if (issue_s && (mode_r == BIAS_MODE_CH)) begin
                if (round_end_s) begin
                    w_cnt_r <= 32'd0;
                    addr_r  <= base_addr_r;
                    x_cnt_r <= x_cnt_r + 16'd1;
                end else begin
                    w_cnt_r <= w_cnt_r + 32'd1;
                    addr_r  <= addr_r + BM_AW'(1);
                end
            end
            if (rd_data_ok_s && (mode_r == BIAS_MODE_BCAST)) begin
                bcast_r     <= bm_dout[BIAS_W-1:0];
                bcast_vld_r <= 1'b1;
            end
            if (emit_s) begin
                wr_cnt_r <= wr_cnt_r + 32'd1;
                lane_r   <= pop_s ? '0 : lane_r + LANE_W'(1);
            end
        end
    end

    // Outstanding-read credit; on abort the in-flight reads become reads to discard.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_r <= '0;
            drop_r     <= '0;
        end else if (abort) begin
            inflight_r <= '0;
            drop_r     <= drop_r - IW'(data_drop_s) + inflight_upd_s;
        end else begin
            inflight_r <= inflight_upd_s;
            drop_r     <= drop_r - IW'(data_drop_s);
        end
    end

    // Registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            bm_rd_en_r   <= 1'b0;
            bm_rd_addr_r <= '0;
            fifo_wr_en_r <= 1'b0;
            fifo_din_r   <= '0;
        end else begin
            busy_r       <= (state_next != ST_IDLE);
            done_r       <= (state_r == ST_DONE) && !abort;
            bm_rd_en_r   <= issue_s;
            fifo_wr_en_r <= emit_s;
            if (issue_s) begin
                bm_rd_addr_r <= addr_r;
            end
            if (emit_s) begin
                fifo_din_r <= emit_data_s;
            end
        end
    end

    assign busy       = busy_r;
    assign done       = done_r;
    assign bm_rd_en   = bm_rd_en_r;
    assign bm_rd_addr = bm_rd_addr_r;
    assign fifo_wr_en = fifo_wr_en_r;
    assign fifo_din   = fifo_din_r;

endmodule
